sha3_pad_absorb: RTL and testbench
==================================

// Module: sha3_pad_absorb
// PURPOSE
//  Input stage directly upstream of the Keccak permutation core. Packs a 16-bit
//  message word stream into rate-sized blocks and applies SHA-3 pad10*1 with the
//  domain byte. Hands each 1600-bit block (capacity zeroed) to the core over
//  valid/ready. Emits the extra pad-only block when the message ends on a block boundary.
// PARAMETERS
//  W_IN    16    input word width in bits; fixed, and rates are multiples of it
//  W_ST    1600  Keccak state width in bits
// PORTS
//  ACLK        in   1     clock
//  ARESETn     in   1     synchronous active-low reset
//  ID          in   2     mode: 0=SHA3-224 (rate 1152), 1=-256 (1088), 2=-384 (832), 3=-512 (576)
//  in_valid    in   1     input word valid
//  in_ready    out  1     block accepts input word
//  in_data     in   16    message word; [7:0] = earlier byte
//  in_keep     in   2     11=two bytes, 01=low byte only, 00=no bytes (legal only with in_last)
//  in_last     in   1     final word of message
//  blk_valid   out  1     block available to core
//  blk_ready   in   1     core accepts block
//  blk_data    out  1600  block; byte k at bits [8k+7:8k]; bits >= rate are 0
//  blk_last    out  1     block is final (padded) block of message
// BEHAVIOUR
//  Reset: in_ready=0 for one cycle then 1; blk_valid=0, blk_last=0, blk_data=0, FSM=ACCUM.
//  Reset mid-message discards any partial block; no block is emitted afterwards.
//  Transfer on valid&&ready at the rising edge of ACLK, on both interfaces.
//  ID is sampled on the first accepted word of each message. ID changes mid-message are ignored.
//  Word counter widx (7b) places word at bits [16*widx+15:16*widx]; words_per_block = rate/16 (72/68/52/36).
//  FSM ACCUM: in_ready=1. On accept, write the word.
//   - not last & widx==wpb-1 -> EMIT (blk_last=0), widx=0.
//   - last -> pad: domain byte D (0x06) at next free byte position p; 0x80 OR'd into byte rate/8-1.
//     If p == rate/8-1, that byte = D|0x80 (0x86). If p == rate/8 (word filled block), -> EMIT then PADBLK.
//     Otherwise -> EMIT with blk_last=1.
//  FSM EMIT: blk_valid=1, in_ready=0. blk_data/blk_last stable until blk_ready.
//   On accept: buffer cleared to 0. Next state is PADBLK if a pad block is pending, else ACCUM.
//  FSM PADBLK: buffer = D at byte 0, 0x80 at byte rate/8-1; -> EMIT with blk_last=1 (one-cycle state).
//  Block output latency: blk_valid rises the cycle after the completing word is accepted.
//  No in/out overlap: single buffer, throughput 1 block per (wpb+1) cycles minimum.
//  in_keep=01 on a non-last word is a protocol violation; the byte is packed and a stray gap is not closed.
// CONFIGURATION
//  SHA3_SHAKE_EN defined: extra port in_shake (in,1), sampled together with ID.
//   in_shake=1: ID 0=SHAKE128 (rate 1344, 84 words), 1=SHAKE256 (1088); D=0x1F; ID 2/3 behave as 1.
//  Undefined: port absent, SHA3 modes only, D=0x06, counter may be 7b max 72.
// STRUCTURE
//  Package sha3_pkg: mode_e enum, RATE_BITS[] table, WPB[] table, DOM_SHA3=8'h06,
//   DOM_SHAKE=8'h1F, PAD_END=8'h80, state_t FSM enum, W_ST constant.
//  Single module. Pad insertion is a small function in the package (no sub-module needed).
// TESTING
//  1 Empty msg, ID=1: one word keep=00 last=1 -> one block, byte0=0x06, byte135=0x80, blk_last=1, bytes>=136 zero.
//  2 ID=1, 68 words keep=11 (0x0001..0x0044), last on 68th -> block0 = data (blk_last=0); block1 = pad-only 0x06/0x80 (blk_last=1).
//  3 ID=3, 35 words keep=11 + word 36 keep=01 last -> single block, byte71=0x86.
//  4 ID=0, 3 words, blk_ready held 0 for 10 cycles -> blk_data stable, in_ready=0 throughout, no word lost.
//  5 ARESETn low mid-message after 20 words, then a new 1-word msg -> only the new msg's block appears.
//  6 SHA3_SHAKE_EN, in_shake=1, ID=0, empty msg -> byte0=0x1F, byte167=0x80, bits>=1344 zero.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared types, rate tables and pad10*1 helper for the SHA-3 absorb input stage.
package sha3_pkg;

   localparam int unsigned W_IN    = 16;
   localparam int unsigned W_ST    = 1600;
   localparam int unsigned N_BYTES = W_ST / 8;

   typedef enum logic [2:0] {
      M_SHA3_224 = 3'd0,
      M_SHA3_256 = 3'd1,
      M_SHA3_384 = 3'd2,
      M_SHA3_512 = 3'd3,
      M_SHAKE128 = 3'd4
   } mode_e;

   localparam int unsigned RATE_BITS [5] = '{1152, 1088, 832, 576, 1344};
   localparam int unsigned WPB       [5] = '{72, 68, 52, 36, 84};

   localparam logic [7:0] DOM_SHA3  = 8'h06;
   localparam logic [7:0] DOM_SHAKE = 8'h1F;
   localparam logic [7:0] PAD_END   = 8'h80;

   typedef enum logic [1:0] {
      S_ACCUM  = 2'd0,
      S_EMIT   = 2'd1,
      S_PADBLK = 2'd2
   } state_t;

   function automatic logic [6:0] mode_wpb(input mode_e m);
      case (m)
         M_SHA3_224: return 7'(WPB[0]);
         M_SHA3_256: return 7'(WPB[1]);
         M_SHA3_384: return 7'(WPB[2]);
         M_SHA3_512: return 7'(WPB[3]);
         M_SHAKE128: return 7'(WPB[4]);
         default:    return 7'(WPB[1]);
      endcase
   endfunction

   // Domain byte lands at pos and 0x80 at the last rate byte; both OR'd so pos == rbytes-1 gives D|0x80.
   function automatic logic [W_ST-1:0] pad_insert(input logic [W_ST-1:0] blk,
                                                  input logic [7:0]      pos,
                                                  input logic [7:0]      dom,
                                                  input logic [7:0]      rbytes);
      logic [W_ST-1:0] v_blk;
      v_blk = blk;
      for (int unsigned k = 0; k < N_BYTES; k++) begin
         if (k == 32'(pos))
            v_blk[8*k +: 8] = v_blk[8*k +: 8] | dom;
         if (k == 32'(rbytes) - 32'd1)
            v_blk[8*k +: 8] = v_blk[8*k +: 8] | PAD_END;
      end
      return v_blk;
   endfunction

endpackage

// File: rtl/sha3_pad_absorb.sv
// Packs 16-bit message words into rate blocks with SHA-3 pad10*1 and hands them to the Keccak core.
// Optional SHAKE support via `SHA3_SHAKE_EN (adds in_shake).
module sha3_pad_absorb
   import sha3_pkg::*;
(
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic [1:0]        ID,
`ifdef SHA3_SHAKE_EN
   input  logic              in_shake,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [W_IN-1:0]   in_data,
   input  logic [1:0]        in_keep,
   input  logic              in_last,
   output logic              blk_valid,
   input  logic              blk_ready,
   output logic [W_ST-1:0]   blk_data,
   output logic              blk_last
);

   state_t            r_state;
   state_t            w_next;
   logic              r_init;
   logic [W_ST-1:0]   r_buf;
   logic [6:0]        r_widx;
   mode_e             r_mode;
   logic [7:0]        r_dom;
   logic              r_first;
   logic              r_pad_pend;
   logic              r_last;

   mode_e             w_mode;
   logic [7:0]        w_dom;
   logic [6:0]        w_wpb;
   logic [7:0]        w_rbytes;
   logic              w_acc;
   logic              w_blk_acc;
   logic [7:0]        w_nbytes;
   logic [7:0]        w_pos;
   logic [W_IN-1:0]   w_word;
   logic [W_ST-1:0]   w_wr_buf;
   logic [W_ST-1:0]   w_pad_buf;
   logic              w_blk_end;

   // Mode comes live from ID only on the first word; afterwards the latched copy is used.
   always_comb begin
      w_mode = r_mode;
      w_dom  = r_dom;
      if (r_first) begin
`ifdef SHA3_SHAKE_EN
         if (in_shake) begin
            w_dom  = DOM_SHAKE;
            w_mode = (ID == 2'd0) ? M_SHAKE128 : M_SHA3_256;
         end else begin
            w_dom  = DOM_SHA3;
            w_mode = mode_e'({1'b0, ID});
         end
`else
         w_dom  = DOM_SHA3;
         w_mode = mode_e'({1'b0, ID});
`endif
      end
   end

   assign w_wpb     = mode_wpb(w_mode);
   assign w_rbytes  = {w_wpb, 1'b0};
   assign w_acc     = in_valid & in_ready;
   assign w_blk_acc = blk_valid & blk_ready;
   assign w_blk_end = (r_widx == 7'(w_wpb - 7'd1));

   always_comb begin
      case (in_keep)
         2'b11:   w_nbytes = 8'd2;
         2'b01:   w_nbytes = 8'd1;
         default: w_nbytes = 8'd0;
      endcase
   end

   assign w_word = {(in_keep == 2'b11) ? in_data[15:8] : 8'h00,
                    in_keep[0]         ? in_data[7:0]  : 8'h00};
   assign w_pos  = {r_widx, 1'b0} + w_nbytes;

   always_comb begin
      w_wr_buf = r_buf;
      for (int unsigned i = 0; i < W_ST / W_IN; i++) begin
         if (r_widx == 7'(i))
            w_wr_buf[W_IN*i +: W_IN] = w_word;
      end
   end

   assign w_pad_buf = pad_insert(w_wr_buf, w_pos, w_dom, w_rbytes);

   always_ff @(posedge ACLK) begin
      if (!ARESETn)
         r_state <= S_ACCUM;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_ACCUM:  if (w_acc && (in_last || w_blk_end)) w_next = S_EMIT;
         S_EMIT:   if (w_blk_acc) w_next = r_pad_pend ? S_PADBLK : S_ACCUM;
         S_PADBLK: w_next = S_EMIT;
         default:  w_next = S_ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == S_ACCUM) && r_init;
      blk_valid = (r_state == S_EMIT);
      blk_data  = r_buf;
      blk_last  = r_last;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_init     <= 1'b0;
         r_buf      <= '0;
         r_widx     <= '0;
         r_mode     <= M_SHA3_224;
         r_dom      <= DOM_SHA3;
         r_first    <= 1'b1;
         r_pad_pend <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         r_init <= 1'b1;
         case (r_state)
            S_ACCUM: begin
               if (w_acc) begin
                  r_mode  <= w_mode;
                  r_dom   <= w_dom;
                  r_first <= 1'b0;
                  if (in_last) begin
                     r_widx <= '0;
                     // A last word that exactly fills the block leaves no room: pad goes into an extra block.
                     if (w_pos == w_rbytes) begin
                        r_buf      <= w_wr_buf;
                        r_pad_pend <= 1'b1;
                        r_last     <= 1'b0;
                     end else begin
                        r_buf  <= w_pad_buf;
                        r_last <= 1'b1;
                     end
                  end else begin
                     r_buf  <= w_wr_buf;
                     r_last <= 1'b0;
                     r_widx <= w_blk_end ? 7'd0 : 7'(r_widx + 7'd1);
                  end
               end
            end
            S_EMIT: begin
               if (w_blk_acc) begin
                  r_buf  <= '0;
                  r_last <= 1'b0;
                  if (r_last)
                     r_first <= 1'b1;
               end
            end
            S_PADBLK: begin
               r_buf      <= pad_insert('0, 8'd0, r_dom, w_rbytes);
               r_last     <= 1'b1;
               r_pad_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha3_pad_absorb.sv
// Directed bench for sha3_pad_absorb; the SHAKE case is built only with `SHA3_SHAKE_EN.
module tb_sha3_pad_absorb;
   import sha3_pkg::*;

   logic            ACLK      = 1'b0;
   logic            ARESETn   = 1'b0;
   logic [1:0]      ID        = 2'd0;
   logic            in_valid  = 1'b0;
   logic            in_ready;
   logic [15:0]     in_data   = '0;
   logic [1:0]      in_keep   = '0;
   logic            in_last   = 1'b0;
   logic            blk_valid;
   logic            blk_ready = 1'b0;
   logic [1599:0]   blk_data;
   logic            blk_last;
`ifdef SHA3_SHAKE_EN
   logic            in_shake  = 1'b0;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] e_bytes [200];

   always #5 ACLK = ~ACLK;

   sha3_pad_absorb u_dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .ID        (ID),
`ifdef SHA3_SHAKE_EN
      .in_shake  (in_shake),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_keep   (in_keep),
      .in_last   (in_last),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic exp_clear();
      for (int k = 0; k < 200; k++) e_bytes[k] = 8'h00;
   endtask

   function automatic int count_bad(input logic [1599:0] d);
      int n = 0;
      for (int k = 0; k < 200; k++)
         if (d[8*k +: 8] !== e_bytes[k]) n++;
      return n;
   endfunction

   task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l);
      int n = 0;
      @(negedge ACLK);
      in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
      while (!in_ready && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge ACLK);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic get_blk(input int hold, output logic [1599:0] d, output logic l,
                          output int unstable, output int rdy_seen);
      int n = 0;
      unstable = 0;
      rdy_seen = 0;
      @(negedge ACLK);
      while (!blk_valid && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      if (!blk_valid) check("blk_timeout", {63'd0, blk_valid}, 64'd1);
      d = blk_data;
      l = blk_last;
      for (int i = 0; i < hold; i++) begin
         @(negedge ACLK);
         if (blk_data !== d || blk_last !== l || !blk_valid) unstable++;
         if (in_ready) rdy_seen++;
      end
      blk_ready = 1'b1;
      @(posedge ACLK);
      #1;
      blk_ready = 1'b0;
   endtask

   logic [1599:0] bd;
   logic          bl;
   int            us, rs, nv;

   initial begin
      // Reset state
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
      check("rst_blk_last", {63'd0, blk_last}, 64'd0);
      check("rst_blk_data_or", {63'd0, |blk_data}, 64'd0);
      ARESETn = 1'b1;
      #1;
      check("rst_rel_in_ready", {63'd0, in_ready}, 64'd0);
      @(negedge ACLK);
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // T1: empty message, SHA3-256
      ID = 2'd1;
      send(16'h0000, 2'b00, 1'b1);
      get_blk(0, bd, bl, us, rs);
      exp_clear(); e_bytes[0] = 8'h06; e_bytes[135] = 8'h80;
      check("t1_byte0", {56'd0, bd[7:0]}, 64'h06);
      check("t1_byte135", {56'd0, bd[1087:1080]}, 64'h80);
      check("t1_last", {63'd0, bl}, 64'd1);
      check("t1_bad_bytes", 64'(count_bad(bd)), 64'd0);

      // T2: 68 full words, block boundary -> extra pad-only block
      ID = 2'd1;
      for (int i = 1; i <= 68; i++) send(16'(i), 2'b11, (i == 68));
      get_blk(0, bd, bl, us, rs);
      exp_clear();
      for (int i = 1; i <= 68; i++) e_bytes[2*(i-1)] = 8'(i);
      check("t2_b0_byte134", {56'd0, bd[1079:1072]}, 64'h44);
      check("t2_b0_last", {63'd0, bl}, 64'd0);
      check("t2_b0_bad_bytes", 64'(count_bad(bd)), 64'd0);
      get_blk(0, bd, bl, us, rs);
      exp_clear(); e_bytes[0] = 8'h06; e_bytes[135] = 8'h80;
      check("t2_b1_last", {63'd0, bl}, 64'd1);
      check("t2_b1_bad_bytes", 64'(count_bad(bd)), 64'd0);

      // T3: SHA3-512, 71 bytes -> 0x86 in last rate byte; ID change after first word ignored
      exp_clear();
      ID = 2'd3;
      for (int i = 0; i < 35; i++) begin
         send(16'hA000 + 16'(i), 2'b11, 1'b0);
         ID = 2'd0;
         e_bytes[2*i]   = 8'(i);
         e_bytes[2*i+1] = 8'hA0;
      end
      send(16'h55AA, 2'b01, 1'b1);
      e_bytes[70] = 8'hAA; e_bytes[71] = 8'h86;
      get_blk(0, bd, bl, us, rs);
      check("t3_byte71", {56'd0, bd[575:568]}, 64'h86);
      check("t3_last", {63'd0, bl}, 64'd1);
      check("t3_bad_bytes", 64'(count_bad(bd)), 64'd0);

      // T4: SHA3-224, back-pressure for 10 cycles while a word is offered
      ID = 2'd0;
      send(16'h1111, 2'b11, 1'b0);
      send(16'h2222, 2'b11, 1'b0);
      send(16'h3333, 2'b11, 1'b1);
      @(negedge ACLK);
      in_valid = 1'b1; in_data = 16'hDEAD; in_keep = 2'b11; in_last = 1'b1;
      get_blk(10, bd, bl, us, rs);
      in_valid = 1'b0; in_last = 1'b0;
      exp_clear();
      for (int k = 0; k < 2; k++) begin
         e_bytes[k] = 8'h11; e_bytes[2+k] = 8'h22; e_bytes[4+k] = 8'h33;
      end
      e_bytes[6] = 8'h06; e_bytes[143] = 8'h80;
      check("t4_unstable_cycles", 64'(us), 64'd0);
      check("t4_in_ready_cycles", 64'(rs), 64'd0);
      check("t4_bad_bytes", 64'(count_bad(bd)), 64'd0);
      check("t4_last", {63'd0, bl}, 64'd1);

      // T5: reset in the middle of a SHA3-384 message
      ID = 2'd2;
      for (int i = 0; i < 20; i++) send(16'hC0C0 + 16'(i), 2'b11, 1'b0);
      @(negedge ACLK);
      ARESETn = 1'b0;
      repeat (2) @(negedge ACLK);
      check("t5_rst_blk_valid", {63'd0, blk_valid}, 64'd0);
      check("t5_rst_in_ready", {63'd0, in_ready}, 64'd0);
      ARESETn = 1'b1;
      send(16'hBEEF, 2'b11, 1'b1);
      get_blk(0, bd, bl, us, rs);
      exp_clear(); e_bytes[0] = 8'hEF; e_bytes[1] = 8'hBE; e_bytes[2] = 8'h06; e_bytes[103] = 8'h80;
      check("t5_bad_bytes", 64'(count_bad(bd)), 64'd0);
      check("t5_last", {63'd0, bl}, 64'd1);
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ACLK);
         if (blk_valid) nv++;
      end
      check("t5_no_extra_blk", 64'(nv), 64'd0);

`ifdef SHA3_SHAKE_EN
      // T6: SHAKE128 empty message
      in_shake = 1'b1;
      ID = 2'd0;
      send(16'h0000, 2'b00, 1'b1);
      in_shake = 1'b0;
      get_blk(0, bd, bl, us, rs);
      exp_clear(); e_bytes[0] = 8'h1F; e_bytes[167] = 8'h80;
      check("t6_byte0", {56'd0, bd[7:0]}, 64'h1F);
      check("t6_bad_bytes", 64'(count_bad(bd)), 64'd0);
      check("t6_last", {63'd0, bl}, 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
